team_06_audio_sample_buffer: RTL and testbench
==============================================

TEAM_06_AUDIO_SAMPLE_BUFFER -- requirements
Module: team_06_audio_sample_buffer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter WIDTH, default 8, SHALL set the sample width.
REQ-003 Parameter DEPTH, default 8, SHALL set the FIFO entry count and SHALL be a power of two.
REQ-004 Parameter DIV_W, default 16, SHALL set the width of the rate divider.
REQ-005 Port clk  input  1  SHALL be the system clock; all state changes on its rising edge.
REQ-006 Port nrst  input  1  SHALL be the asynchronous active-low reset.
REQ-007 Port en  input  1  SHALL enable sample pacing.
REQ-008 Port rate_div  input  DIV_W  SHALL be the clocks per sample period minus one.
REQ-009 Port in_data  input  WIDTH  SHALL be the producer sample.
REQ-010 Port in_valid  input  1  SHALL indicate that in_data is valid.
REQ-011 Port in_ready  output  1  SHALL indicate that the FIFO can accept a sample.
REQ-012 Port clr_underrun  input  1  SHALL clear the sticky underrun flag.
REQ-013 Port sample_out  output  WIDTH  SHALL be the current sample and SHALL drive the DAC serializer parallel input.
REQ-014 Port sample_strobe  output  1  SHALL pulse for one cycle when sample_out takes a new value.
REQ-015 Port underrun  output  1  SHALL be the sticky flag indicating a tick occurred with the FIFO empty.
REQ-016 Port fill_level  output  $clog2(DEPTH)+1  SHALL give the current FIFO occupancy.

Function
REQ-017 A push SHALL occur on a rising edge where in_valid and in_ready are both 1, storing in_data at the write pointer.
REQ-018 in_ready SHALL be combinational and equal to (fill_level != DEPTH).
REQ-019 Pushes SHALL be accepted regardless of en.
REQ-020 When en=1, a pacing counter SHALL increment each cycle; a tick SHALL occur in any cycle where counter >= rate_div, and the counter SHALL then reload to 0.
REQ-021 Because the comparison is ">=", lowering rate_div mid-period SHALL cause a tick on the next cycle and SHALL NOT stall the counter.
REQ-022 With rate_div=0 and en=1, a tick SHALL occur every cycle.
REQ-023 When en=0, the counter SHALL reload to 0, no ticks SHALL occur, and sample_out SHALL hold its value.
REQ-024 The first tick SHALL occur rate_div+1 cycles after en rises.
REQ-025 On a tick with the FIFO non-empty, the FIFO head SHALL be popped and registered into sample_out.
REQ-026 On a tick with the FIFO empty, sample_out SHALL load the midscale mute value (1 << (WIDTH-1)), i.e. 0x80, and underrun SHALL be set.
REQ-027 sample_strobe SHALL be registered and SHALL be 1 exactly in the cycle following a tick, coincident with the new sample_out value, including mute loads.
REQ-028 On simultaneous push and pop, fill_level SHALL be unchanged and the push SHALL be stored.
REQ-029 When the FIFO is empty, a push in the same cycle as a tick SHALL NOT bypass to the output: the tick SHALL produce a mute load and underrun, and the pushed sample SHALL remain queued.
REQ-030 When the FIFO is full, in_ready SHALL be 0, any in_valid SHALL be ignored, and a pop in that cycle SHALL NOT admit a same-cycle push.
REQ-031 Read and write pointers SHALL wrap modulo DEPTH, and FIFO ordering SHALL be strictly first-in, first-out.
REQ-032 clr_underrun=1 SHALL clear underrun on the next edge; if a new underrun occurs in the same cycle, set SHALL take priority.

Reset
REQ-033 While nrst=0, the block SHALL asynchronously force: pointers, fill_level and the pacing counter to 0; sample_out to 0x80; sample_strobe to 0; underrun to 0; in_ready to 1.
REQ-034 Reset asserted mid-operation SHALL discard all queued samples, and after release no stale data SHALL be output.
REQ-035 The first tick after reset release SHALL occur rate_div+1 cycles after both nrst and en are high.

Verification
REQ-036 Reset scenario: hold nrst=0 with in_valid=1 -> sample_out=0x80, fill_level=0, in_ready=1, underrun=0, sample_strobe=0.
REQ-037 Ordered-playback scenario: push 0xDB, 0x99, 0xF9, then set en=1 with rate_div=3 -> strobes every 4 cycles; sample_out=0xDB, 0x99, 0xF9, then 0x80 with underrun=1.
REQ-038 Full-FIFO scenario: with en=0, push 9 values 0x01..0x09 -> fill_level=8, in_ready=0, 0x09 dropped; playback yields 0x01..0x08.
REQ-039 Concurrent push/pop scenario: at fill_level=3, push on a tick cycle -> fill_level stays 3; underrun clear plus set in the same cycle -> underrun=1.
REQ-040 Pause scenario: drop en for 50 cycles mid-run -> no strobes and sample_out held; after en returns, the next strobe follows rate_div+1 cycles later.
REQ-041 Mid-operation reset scenario: pulse nrst low with fill_level=5 -> fill_level=0 and sample_out=0x80 immediately without waiting for a clock edge; after release, push 0xF9 -> first strobe outputs 0xF9.

Source files
------------

// File: rtl/team_06_audio_sample_buffer.sv
// Audio sample buffer: a FIFO filled by a producer and drained at a paced
// sample rate into a registered DAC sample. An empty FIFO at a tick plays
// midscale mute and sets a sticky underrun flag.
module team_06_audio_sample_buffer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DIV_W = 16
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       en,
  input  logic [DIV_W-1:0]           rate_div,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       clr_underrun,
  output logic [WIDTH-1:0]           sample_out,
  output logic                       sample_strobe,
  output logic                       underrun,
  output logic [$clog2(DEPTH):0]     fill_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [WIDTH-1:0] MUTE = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [DIV_W-1:0] pace_cnt;

  logic fifo_empty;
  logic fifo_full;
  logic tick;
  logic push;
  logic pop;

  // Handshake, pacing tick and FIFO transfer qualifiers
  always_comb begin
    fifo_empty = (fill_level == LW'(0));
    fifo_full  = (fill_level == LW'(DEPTH));
    in_ready   = !fifo_full;
    tick       = en && (pace_cnt >= rate_div);
    push       = in_valid && !fifo_full;
    pop        = tick && !fifo_empty;
  end

  // Pacing counter: free-runs while enabled, reloads on tick or when paused
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pace_cnt <= '0;
    end else if (!en || tick) begin
      pace_cnt <= '0;
    end else begin
      pace_cnt <= pace_cnt + DIV_W'(1);
    end
  end

  // Sample storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Read/write pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Occupancy tracking; simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fill_level <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   fill_level <= fill_level + LW'(1);
        2'b01:   fill_level <= fill_level - LW'(1);
        default: fill_level <= fill_level;
      endcase
    end
  end

  // Output sample: FIFO head on tick, mute when the FIFO was empty
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sample_out    <= MUTE;
      sample_strobe <= 1'b0;
    end else begin
      sample_strobe <= tick;
      if (tick) begin
        sample_out <= fifo_empty ? MUTE : mem[rd_ptr];
      end
    end
  end

  // Sticky underrun; a new underrun wins over a same-cycle clear
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      underrun <= 1'b0;
    end else if (tick && fifo_empty) begin
      underrun <= 1'b1;
    end else if (clr_underrun) begin
      underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_team_06_audio_sample_buffer.sv
// Bench for the audio sample buffer: queue-based playback model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_team_06_audio_sample_buffer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned DIV_W = 16;

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic             en = 1'b0;
  logic [DIV_W-1:0] rate_div = '0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             clr_underrun = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] sample_out;
  logic             sample_strobe;
  logic             underrun;
  logic [3:0]       fill_level;

  int n_cmp = 0;
  int n_bad = 0;

  team_06_audio_sample_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .nrst(nrst), .en(en), .rate_div(rate_div),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .clr_underrun(clr_underrun), .sample_out(sample_out),
    .sample_strobe(sample_strobe), .underrun(underrun), .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Playback model: a queue of pending samples and the period counter
  byte unsigned q[$];
  int           m_cnt = 0;
  logic [7:0]   m_out = 8'h80;
  logic         m_strobe = 1'b0;
  logic         m_under = 1'b0;

  always @(posedge clk or negedge nrst) begin
    bit tk;
    bit was_empty;
    bit can_push;
    if (!nrst) begin
      q.delete();
      m_cnt    = 0;
      m_out    = 8'h80;
      m_strobe = 1'b0;
      m_under  = 1'b0;
    end else begin
      tk        = en && (m_cnt >= int'(rate_div));
      was_empty = (q.size() == 0);
      can_push  = in_valid && (q.size() < DEPTH);
      if (!en || tk) m_cnt = 0;
      else m_cnt = m_cnt + 1;
      if (tk) begin
        if (was_empty) m_out = 8'h80;
        else m_out = q.pop_front();
      end
      if (can_push) q.push_back(in_data);
      if (tk && was_empty) m_under = 1'b1;
      else if (clr_underrun) m_under = 1'b0;
      m_strobe = tk;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    check("sample_out", 32'(sample_out), 32'(m_out));
    check("sample_strobe", 32'(sample_strobe), 32'(m_strobe));
    check("underrun", 32'(underrun), 32'(m_under));
    check("fill_level", 32'(fill_level), 32'(q.size()));
    check("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
  end

  task automatic wait_strobe(input int max_cyc, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!sample_strobe && n < max_cyc);
    if (!sample_strobe) begin
      n_cmp++;
      n_bad++;
      $display("FAIL strobe_timeout: no strobe within %0d cycles", n);
    end
  endtask

  task automatic push_one(input logic [7:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
  endtask

  initial begin
    int n;
    int strobes;
    logic [7:0] held;
    logic [7:0] exp_vals [4];
    exp_vals[0] = 8'hDB; exp_vals[1] = 8'h99; exp_vals[2] = 8'hF9; exp_vals[3] = 8'h80;

    // Reset held with in_valid asserted
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) @(negedge clk);
    check("rst_sample_out", 32'(sample_out), 32'h80);
    check("rst_fill", 32'(fill_level), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_strobe", 32'(sample_strobe), 32'd0);
    in_valid = 1'b0;
    nrst = 1'b1;

    // Ordered playback at rate_div=3
    push_one(8'hDB);
    push_one(8'h99);
    push_one(8'hF9);
    @(negedge clk);
    in_valid = 1'b0;
    rate_div = 16'd3;
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_strobe(20, n);
      check("play_period", 32'(n), 32'd4);
      check("play_value", 32'(sample_out), 32'(exp_vals[i]));
    end
    check("play_underrun", 32'(underrun), 32'd1);
    @(negedge clk);
    en = 1'b0;
    clr_underrun = 1'b1;
    @(negedge clk);
    clr_underrun = 1'b0;
    check("clr_underrun", 32'(underrun), 32'd0);

    // Fill to capacity; the ninth value is dropped
    for (int i = 1; i <= 9; i++) push_one(8'(i));
    @(negedge clk);
    in_valid = 1'b0;
    check("full_fill", 32'(fill_level), 32'd8);
    check("full_ready", 32'(in_ready), 32'd0);
    rate_div = 16'd0;
    en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      wait_strobe(4, n);
      check("full_period", 32'(n), 32'd1);
      check("full_value", 32'(sample_out), 32'(i));
    end
    wait_strobe(4, n);
    check("full_drained_mute", 32'(sample_out), 32'h80);
    @(negedge clk);
    en = 1'b0;
    clr_underrun = 1'b1;
    @(negedge clk);
    clr_underrun = 1'b0;

    // Push on a tick cycle at fill_level=3, then clear+set underrun together
    push_one(8'h11);
    push_one(8'h22);
    push_one(8'h33);
    @(negedge clk);
    in_valid = 1'b0;
    rate_div = 16'd2;
    en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h44;
    @(negedge clk);
    check("conc_fill", 32'(fill_level), 32'd3);
    check("conc_value", 32'(sample_out), 32'h11);
    check("conc_strobe", 32'(sample_strobe), 32'd1);
    in_valid = 1'b0;
    rate_div = 16'd0;
    clr_underrun = 1'b1;
    exp_vals[0] = 8'h22; exp_vals[1] = 8'h33; exp_vals[2] = 8'h44; exp_vals[3] = 8'h80;
    for (int i = 0; i < 4; i++) begin
      wait_strobe(4, n);
      check("conc_drain", 32'(sample_out), 32'(exp_vals[i]));
    end
    check("set_beats_clear", 32'(underrun), 32'd1);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    clr_underrun = 1'b0;
    check("clear_after", 32'(underrun), 32'd0);

    // Lowering rate_div mid-period, then a 50-cycle pause
    for (int i = 0; i < 5; i++) push_one(8'hA1 + 8'(i));
    @(negedge clk);
    in_valid = 1'b0;
    rate_div = 16'd5;
    en = 1'b1;
    wait_strobe(20, n);
    check("pace_first", 32'(n), 32'd6);
    check("pace_value", 32'(sample_out), 32'hA1);
    repeat (3) @(negedge clk);
    rate_div = 16'd1;
    wait_strobe(4, n);
    check("lowered_period", 32'(n), 32'd1);
    check("lowered_value", 32'(sample_out), 32'hA2);
    @(negedge clk);
    rate_div = 16'd5;
    en = 1'b0;
    held = sample_out;
    strobes = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (sample_strobe) strobes++;
    end
    check("pause_strobes", 32'(strobes), 32'd0);
    check("pause_hold", 32'(sample_out), 32'(held));
    @(negedge clk);
    en = 1'b1;
    wait_strobe(20, n);
    check("resume_period", 32'(n), 32'd6);
    check("resume_value", 32'(sample_out), 32'hA3);

    // Asynchronous reset with five samples queued
    @(negedge clk);
    en = 1'b0;
    push_one(8'hB1);
    push_one(8'hB2);
    push_one(8'hB3);
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_reset_fill", 32'(fill_level), 32'd5);
    #2;
    nrst = 1'b0;
    #1;
    check("async_fill", 32'(fill_level), 32'd0);
    check("async_sample", 32'(sample_out), 32'h80);
    check("async_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hF9;
    rate_div = 16'd1;
    en = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_strobe(8, n);
    check("post_reset_period", 32'(n), 32'd1);
    check("post_reset_value", 32'(sample_out), 32'hF9);
    wait_strobe(8, n);
    check("no_stale_data", 32'(sample_out), 32'h80);
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
